// File: rtl/rom_port_arbiter.sv
// Shares one registered-output ROM between the 68k bus and the video fetch path.
// Video has priority, and a streak limit bounds how long the CPU can wait.
// Define ROM_ARB_STATS_EN to build the grant counter and the CPU wait-maximum counter.
module rom_port_arbiter #(
  parameter int AW             = 18,
  parameter int DW             = 16,
  parameter int MAX_VID_STREAK = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_as,
  input  logic [AW-1:0] cpu_addr,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_dtack_b,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic          vid_gnt,
  output logic [DW-1:0] vid_rdata,
  output logic          vid_valid,
  output logic          mem_en,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_rdata,
  output logic [15:0]   stat_vid_cnt,
  output logic [15:0]   stat_cpu_wmax
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_VID,
    S_RD_CPU,
    S_CAP_VID,
    S_CAP_CPU
  } state_t;

  state_t     r_state;
  logic       r_cpu_served;
  logic [3:0] r_streak;

  logic w_cpu_pend;
  logic w_streak_max;
  logic w_vid_win;
  logic w_cpu_win;

  assign w_cpu_pend   = cpu_as & ~r_cpu_served;
  assign w_streak_max = (r_streak == 4'(MAX_VID_STREAK));
  assign w_vid_win    = (r_state == S_IDLE) & vid_req & ~(w_cpu_pend & w_streak_max);
  assign w_cpu_win    = (r_state == S_IDLE) & ~w_vid_win & w_cpu_pend;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cpu_served <= 1'b0;
      r_streak     <= 4'd0;
      mem_en       <= 1'b0;
      mem_addr     <= '0;
      vid_gnt      <= 1'b0;
      vid_valid    <= 1'b0;
      vid_rdata    <= '0;
      cpu_rdata    <= '0;
      cpu_dtack_b  <= 1'b1;
    end else begin
      // NOTE: pulse outputs default low here; a later assignment in the same block wins.
      mem_en    <= 1'b0;
      vid_gnt   <= 1'b0;
      vid_valid <= 1'b0;

      // Dropping the address strobe ends the bus cycle and re-arms the CPU.
      if (!cpu_as) begin
        r_cpu_served <= 1'b0;
        cpu_dtack_b  <= 1'b1;
      end

      if (!w_cpu_pend || w_cpu_win) begin
        r_streak <= 4'd0;
      end else if (w_vid_win && r_streak != 4'hF) begin
        r_streak <= r_streak + 4'd1;
      end

      case (r_state)
        S_IDLE: begin
          if (w_vid_win) begin
            r_state  <= S_RD_VID;
            mem_en   <= 1'b1;
            mem_addr <= vid_addr;
            vid_gnt  <= 1'b1;
          end else if (w_cpu_win) begin
            r_state      <= S_RD_CPU;
            mem_en       <= 1'b1;
            mem_addr     <= cpu_addr;
            r_cpu_served <= 1'b1;
          end
        end
        S_RD_VID: r_state <= S_CAP_VID;
        S_RD_CPU: r_state <= S_CAP_CPU;
        S_CAP_VID: begin
          vid_rdata <= mem_rdata;
          vid_valid <= 1'b1;
          r_state   <= S_IDLE;
        end
        S_CAP_CPU: begin
          // An aborted CPU cycle clears r_cpu_served, so its data is dropped here.
          if (cpu_as && r_cpu_served) begin
            cpu_rdata   <= mem_rdata;
            cpu_dtack_b <= 1'b0;
          end
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef ROM_ARB_STATS_EN
  logic [15:0] r_vid_cnt;
  logic [15:0] r_cpu_wait;
  logic [15:0] r_cpu_wmax;
  logic [15:0] w_wait_now;

  // Wait length counts every pending cycle, including the cycle the CPU wins.
  assign w_wait_now = (r_cpu_wait == 16'hFFFF) ? r_cpu_wait : r_cpu_wait + 16'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vid_cnt  <= 16'd0;
      r_cpu_wait <= 16'd0;
      r_cpu_wmax <= 16'd0;
    end else begin
      if (w_vid_win) r_vid_cnt <= r_vid_cnt + 16'd1;
      r_cpu_wait <= w_cpu_pend ? w_wait_now : 16'd0;
      if (w_cpu_win && (w_wait_now > r_cpu_wmax)) r_cpu_wmax <= w_wait_now;
    end
  end

  assign stat_vid_cnt  = r_vid_cnt;
  assign stat_cpu_wmax = r_cpu_wmax;
`else
  assign stat_vid_cnt  = 16'd0;
  assign stat_cpu_wmax = 16'd0;
`endif

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed bench for rom_port_arbiter: a registered ROM model plus one task per scenario.
// Stat expectations follow ROM_ARB_STATS_EN (zero when the macro is undefined).
module tb_rom_port_arbiter;
  localparam int AW = 18;
  localparam int DW = 16;

`ifdef ROM_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cpu_as = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_dtack_b;
  logic          vid_req = 1'b0;
  logic [AW-1:0] vid_addr = '0;
  logic          vid_gnt;
  logic [DW-1:0] vid_rdata;
  logic          vid_valid;
  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata = '0;
  logic [15:0]   stat_vid_cnt;
  logic [15:0]   stat_cpu_wmax;

  int n_checks = 0;
  int n_bad    = 0;

  always #5 clk = ~clk;

  rom_port_arbiter #(.AW(AW), .DW(DW), .MAX_VID_STREAK(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_as(cpu_as), .cpu_addr(cpu_addr), .cpu_rdata(cpu_rdata), .cpu_dtack_b(cpu_dtack_b),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_gnt(vid_gnt), .vid_rdata(vid_rdata),
    .vid_valid(vid_valid), .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .stat_vid_cnt(stat_vid_cnt), .stat_cpu_wmax(stat_cpu_wmax)
  );

  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    case (a)
      18'h00010: rom_word = 16'h4E71;
      18'h00400: rom_word = 16'h1234;
      default:   rom_word = a[15:0] ^ 16'hA5A5;
    endcase
  endfunction

  // Registered-output ROM: data appears the cycle after mem_en.
  always @(posedge clk) if (mem_en) mem_rdata <= rom_word(mem_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    cpu_as  = 1'b0;
    vid_req = 1'b0;
    repeat (4) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (mem_en !== 1'b0) begin n_bad++; $display("FAIL reset_mem_en: got %b want 0", mem_en); end
    n_checks++; if (mem_addr !== 18'h0) begin n_bad++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
    n_checks++; if (vid_gnt !== 1'b0 || vid_valid !== 1'b0) begin n_bad++; $display("FAIL reset_vid: gnt=%b valid=%b want 0 0", vid_gnt, vid_valid); end
    n_checks++; if (vid_rdata !== 16'h0 || cpu_rdata !== 16'h0) begin n_bad++; $display("FAIL reset_rdata: vid=%h cpu=%h want 0 0", vid_rdata, cpu_rdata); end
    n_checks++; if (cpu_dtack_b !== 1'b1) begin n_bad++; $display("FAIL reset_dtack: got %b want 1", cpu_dtack_b); end
    n_checks++; if (stat_vid_cnt !== 16'h0 || stat_cpu_wmax !== 16'h0) begin n_bad++; $display("FAIL reset_stats: cnt=%0d wmax=%0d want 0 0", stat_vid_cnt, stat_cpu_wmax); end
  endtask

  task automatic test_vid_read();
    vid_addr = 18'h00010;
    vid_req  = 1'b1;
    tick();  // cycle 1
    n_checks++; if (vid_gnt !== 1'b1 || mem_en !== 1'b1) begin n_bad++; $display("FAIL vid_c1_gnt: gnt=%b en=%b want 1 1", vid_gnt, mem_en); end
    n_checks++; if (mem_addr !== 18'h00010) begin n_bad++; $display("FAIL vid_c1_addr: got %h want 00010", mem_addr); end
    vid_req = 1'b0;
    tick();  // cycle 2
    n_checks++; if (vid_gnt !== 1'b0 || vid_valid !== 1'b0 || mem_en !== 1'b0) begin n_bad++; $display("FAIL vid_c2: gnt=%b valid=%b en=%b want 0 0 0", vid_gnt, vid_valid, mem_en); end
    tick();  // cycle 3
    n_checks++; if (vid_valid !== 1'b1 || vid_rdata !== 16'h4E71) begin n_bad++; $display("FAIL vid_c3_data: valid=%b data=%h want 1 4e71", vid_valid, vid_rdata); end
    tick();
    n_checks++; if (vid_valid !== 1'b0) begin n_bad++; $display("FAIL vid_c4_pulse: valid=%b want 0", vid_valid); end
    idle_bus();
  endtask

  task automatic test_cpu_read();
    cpu_addr = 18'h00400;
    cpu_as   = 1'b1;
    tick();  // cycle 1
    n_checks++; if (mem_en !== 1'b1 || mem_addr !== 18'h00400 || vid_gnt !== 1'b0) begin n_bad++; $display("FAIL cpu_c1: en=%b addr=%h gnt=%b want 1 00400 0", mem_en, mem_addr, vid_gnt); end
    tick();  // cycle 2
    n_checks++; if (cpu_dtack_b !== 1'b1) begin n_bad++; $display("FAIL cpu_c2_dtack: got %b want 1", cpu_dtack_b); end
    tick();  // cycle 3
    n_checks++; if (cpu_dtack_b !== 1'b0 || cpu_rdata !== 16'h1234) begin n_bad++; $display("FAIL cpu_c3_data: dtack=%b data=%h want 0 1234", cpu_dtack_b, cpu_rdata); end
    repeat (3) tick();
    n_checks++; if (cpu_dtack_b !== 1'b0 || mem_en !== 1'b0) begin n_bad++; $display("FAIL cpu_hold: dtack=%b en=%b want 0 0", cpu_dtack_b, mem_en); end
    cpu_as = 1'b0;
    tick();
    n_checks++; if (cpu_dtack_b !== 1'b1) begin n_bad++; $display("FAIL cpu_release: dtack=%b want 1", cpu_dtack_b); end
    idle_bus();
  endtask

  task automatic test_streak();
    int n_vid_before = 0;
    bit cpu_seen = 1'b0;
    bit vid_after = 1'b0;
    vid_addr = 18'h00020;
    cpu_addr = 18'h00400;
    vid_req  = 1'b1;
    cpu_as   = 1'b1;
    for (int i = 0; i < 60 && !vid_after; i++) begin
      tick();
      if (vid_gnt === 1'b1) begin
        if (cpu_seen) vid_after = 1'b1;
        else n_vid_before++;
      end else if (mem_en === 1'b1 && mem_addr === 18'h00400) begin
        cpu_seen = 1'b1;
      end
    end
    n_checks++; if (n_vid_before != 4) begin n_bad++; $display("FAIL streak_count: got %0d want 4", n_vid_before); end
    n_checks++; if (!cpu_seen || !vid_after) begin n_bad++; $display("FAIL streak_order: cpu=%0d vid_resumed=%0d want 1 1", cpu_seen, vid_after); end
    n_checks++; if (cpu_dtack_b !== 1'b0 || cpu_rdata !== 16'h1234) begin n_bad++; $display("FAIL streak_dtack: dtack=%b data=%h want 0 1234", cpu_dtack_b, cpu_rdata); end
    idle_bus();
  endtask

  task automatic test_simultaneous();
    vid_addr = 18'h00010;
    cpu_addr = 18'h00400;
    vid_req  = 1'b1;
    cpu_as   = 1'b1;
    tick();  // cycle 1
    n_checks++; if (vid_gnt !== 1'b1 || mem_addr !== 18'h00010) begin n_bad++; $display("FAIL simul_vid_first: gnt=%b addr=%h want 1 00010", vid_gnt, mem_addr); end
    vid_req = 1'b0;
    tick();
    tick();  // cycle 3
    n_checks++; if (vid_valid !== 1'b1 || vid_rdata !== 16'h4E71 || cpu_dtack_b !== 1'b1) begin n_bad++; $display("FAIL simul_c3: valid=%b data=%h dtack=%b want 1 4e71 1", vid_valid, vid_rdata, cpu_dtack_b); end
    tick();  // cycle 4
    n_checks++; if (mem_en !== 1'b1 || mem_addr !== 18'h00400) begin n_bad++; $display("FAIL simul_cpu_rd: en=%b addr=%h want 1 00400", mem_en, mem_addr); end
    tick();  // cycle 5
    n_checks++; if (cpu_dtack_b !== 1'b1) begin n_bad++; $display("FAIL simul_c5_dtack: got %b want 1", cpu_dtack_b); end
    tick();  // cycle 6
    n_checks++; if (cpu_dtack_b !== 1'b0 || cpu_rdata !== 16'h1234) begin n_bad++; $display("FAIL simul_c6_dtack: dtack=%b data=%h want 0 1234", cpu_dtack_b, cpu_rdata); end
    idle_bus();
  endtask

  task automatic test_cpu_abort();
    bit saw_dtack = 1'b0;
    cpu_addr = 18'h00400;
    cpu_as   = 1'b1;
    tick();  // cycle 1
    n_checks++; if (mem_en !== 1'b1 || mem_addr !== 18'h00400) begin n_bad++; $display("FAIL abort_rd: en=%b addr=%h want 1 00400", mem_en, mem_addr); end
    cpu_as = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (cpu_dtack_b !== 1'b1) saw_dtack = 1'b1;
    end
    n_checks++; if (saw_dtack) begin n_bad++; $display("FAIL abort_dtack: dtack went low, want stay 1"); end
    vid_addr = 18'h00010;
    vid_req  = 1'b1;
    tick();
    n_checks++; if (vid_gnt !== 1'b1 || mem_addr !== 18'h00010) begin n_bad++; $display("FAIL abort_next_gnt: gnt=%b addr=%h want 1 00010", vid_gnt, mem_addr); end
    vid_req = 1'b0;
    tick();
    tick();
    n_checks++; if (vid_valid !== 1'b1 || vid_rdata !== 16'h4E71) begin n_bad++; $display("FAIL abort_next_data: valid=%b data=%h want 1 4e71", vid_valid, vid_rdata); end
    idle_bus();
  endtask

  task automatic test_reset_mid_read();
    bit saw_valid = 1'b0;
    vid_addr = 18'h00033;
    vid_req  = 1'b1;
    tick();  // cycle 1
    n_checks++; if (vid_gnt !== 1'b1) begin n_bad++; $display("FAIL rmid_gnt: got %b want 1", vid_gnt); end
    reset   = 1'b1;
    vid_req = 1'b0;
    tick();
    n_checks++; if (mem_en !== 1'b0 || mem_addr !== 18'h0 || vid_gnt !== 1'b0 || vid_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_outs: en=%b addr=%h gnt=%b valid=%b want 0 0 0 0", mem_en, mem_addr, vid_gnt, vid_valid); end
    n_checks++; if (vid_rdata !== 16'h0 || cpu_rdata !== 16'h0 || cpu_dtack_b !== 1'b1) begin n_bad++; $display("FAIL rmid_data: vid=%h cpu=%h dtack=%b want 0 0 1", vid_rdata, cpu_rdata, cpu_dtack_b); end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (vid_valid !== 1'b0) saw_valid = 1'b1;
    end
    n_checks++; if (saw_valid) begin n_bad++; $display("FAIL rmid_no_valid: vid_valid pulsed after reset"); end
  endtask

  task automatic test_stats();
    int n_gnt = 0;
    bit got_dtack = 1'b0;
    do_reset();
    vid_addr = 18'h00040;
    vid_req  = 1'b1;
    for (int i = 0; i < 100 && n_gnt < 10; i++) begin
      tick();
      if (vid_gnt === 1'b1) n_gnt++;
    end
    n_checks++; if (stat_vid_cnt !== (STATS ? 16'd10 : 16'd0)) begin n_bad++; $display("FAIL stat_vid_cnt: got %0d want %0d", stat_vid_cnt, STATS ? 10 : 0); end
    // CPU arrives the cycle after a grant it did not compete for: worst-case wait.
    cpu_addr = 18'h00400;
    cpu_as   = 1'b1;
    for (int i = 0; i < 40 && !got_dtack; i++) begin
      tick();
      if (cpu_dtack_b === 1'b0) got_dtack = 1'b1;
    end
    n_checks++; if (!got_dtack) begin n_bad++; $display("FAIL stat_cpu_timeout: no dtack within 40 cycles"); end
    n_checks++; if (stat_cpu_wmax !== (STATS ? 16'd15 : 16'd0)) begin n_bad++; $display("FAIL stat_cpu_wmax: got %0d want %0d", stat_cpu_wmax, STATS ? 15 : 0); end
    idle_bus();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_vid_read();
    test_cpu_read();
    test_streak();
    test_simultaneous();
    test_cpu_abort();
    test_reset_mid_read();
    test_stats();
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
